fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 117 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with IDLE/FETCH/DRAIN sequencing, redirect priority and the IF/ID register.
// Define FETCH_PERF_CNT_EN to add the PerfStallCnt stall-cycle counter port.
module fetch_stage (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        JrTaken,
   input  logic [31:0] JrTarget,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemReady,
   input  logic [31:0] IMemData,
   output logic [31:0] ID_PCAddResult,
   output logic [31:0] ID_Instruction,
   output logic        ID_Valid
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] PerfStallCnt
`endif
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]  state;
   logic [31:0] pc;
   logic [31:0] pend_target;
   logic [31:0] sel_target;
   logic [31:0] pc_plus4;
   logic        redirect;

   // Older stages in the pipe win: MEM branch, then EX jr, then ID jump.
   always_comb begin
      redirect = BranchTaken | JrTaken | Jump;
      if (BranchTaken)
         sel_target = BranchTarget;
      else if (JrTaken)
         sel_target = JrTarget;
      else
         sel_target = JumpTarget;
   end

   assign pc_plus4 = pc + 32'd4;
   assign IMemReq  = (state != IDLE);
   assign IMemAddr = pc;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state          <= IDLE;
         pc             <= '0;
         pend_target    <= '0;
         ID_Instruction <= '0;
         ID_PCAddResult <= '0;
         ID_Valid       <= 1'b0;
      end else begin
         case (state)
            IDLE: state <= FETCH;
            FETCH: begin
               if (redirect) begin
                  ID_Valid <= 1'b0;
                  if (IMemReady) begin
                     pc <= sel_target;
                  end else begin
                     pend_target <= sel_target;
                     state       <= DRAIN;
                  end
               end else if (Flush) begin
                  // Word accepted but killed: still step past it.
                  ID_Valid <= 1'b0;
                  if (IMemReady && !Stall)
                     pc <= pc_plus4;
               end else if (!Stall) begin
                  if (IMemReady) begin
                     ID_Instruction <= IMemData;
                     ID_PCAddResult <= pc_plus4;
                     ID_Valid       <= 1'b1;
                     pc             <= pc_plus4;
                  end else begin
                     ID_Valid <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               // The outstanding request at the old PC must complete before retargeting.
               ID_Valid <= 1'b0;
               if (IMemReady) begin
                  pc    <= redirect ? sel_target : pend_target;
                  state <= FETCH;
               end else if (redirect) begin
                  pend_target <= sel_target;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         PerfStallCnt <= '0;
      else if (state != IDLE && (Stall || !IMemReady || state == DRAIN))
         PerfStallCnt <= sat_inc(PerfStallCnt);
   end
`endif

endmodule
